// File: rtl/uart_rx_oversample_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   rx_state_t      : receiver FSM state encoding
//   DEF_CLK_HZ/BAUD/OVS : default clock, bit rate and samples per bit
//   maj3()          : 2-of-3 majority vote used for bit decisions
package uart_rx_oversample_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_CLK_HZ = 48000000;
    localparam int DEF_BAUD   = 9600;
    localparam int DEF_OVS    = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_baud_tick_gen.sv
// Sample-tick divider for the UART receiver.
//   clk, rst : system clock, asynchronous active-high reset
//   en       : count enable
//   clr      : synchronous clear, holds the divider at 0 (wins over en)
//   tick     : one-clk pulse when the divider is at DIV-1 while enabled
module baud_tick_gen #(
    parameter int DIV = 625
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CW'(DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with OVS-times oversampling and 3-sample majority vote.
//   clk, rst  : system clock, asynchronous active-high reset
//   rx        : raw line, idle high, asynchronous to clk
//   data      : last good byte (LSB first on the line)
//   valid     : one-clk strobe, data just updated with a good frame
//   frame_err : one-clk strobe, stop bit sampled low (data untouched)
//   busy      : receiver is inside a frame (state != IDLE)
//   state_dbg : current FSM state, rx_state_t encoding
//
// Output strobes: valid and frame_err are registered, single-cycle, mutually
// exclusive pulses with no back-pressure; a consumer must accept them in the
// cycle they appear (data stays stable until the next valid).
module uart_rx_oversample
    import uart_rx_oversample_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD,
    parameter int OVS    = DEF_OVS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int DIV = CLK_HZ / (BAUD * OVS);

    if (DIV * BAUD * OVS != CLK_HZ) begin : g_div_check
        $error("uart_rx_oversample: CLK_HZ must be an exact multiple of BAUD*OVS");
    end

    // Sample indices inside one bit; decisions use samples 3,4,5.
    localparam logic [2:0] IDX_S3   = 3'd3;
    localparam logic [2:0] IDX_S4   = 3'd4;
    localparam logic [2:0] IDX_S5   = 3'd5;
    localparam logic [2:0] IDX_LAST = 3'(OVS - 1);

    rx_state_t  state, next_state;
    logic [1:0] sync_q;
    logic       rx_s;
    logic       tick;
    logic       div_en;
    logic       start_cond;
    logic [2:0] smp_idx;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       s3, s4;
    logic       bit_val;
    logic       maj_now;
    logic       armed;
    logic       take_byte;
    logic       set_ferr;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end
    assign rx_s = sync_q[1];

    // A start is only accepted once the line has been seen high after a
    // framing error, so a held break is not mistaken for a new frame.
    assign start_cond = (state == ST_IDLE) && armed && !rx_s;

    // Divider runs from the very first low sample; in IDLE it is held at 0.
    assign div_en = (state != ST_IDLE) || start_cond;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .clr (!div_en),
        .tick(tick)
    );

    // Majority using the live third sample, needed for the early stop decision.
    assign maj_now = maj3(s3, s4, rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        take_byte  = 1'b0;
        set_ferr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_cond) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                if (tick && smp_idx == IDX_LAST) begin
                    next_state = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && smp_idx == IDX_LAST && bit_cnt == 3'd7) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at sample 5 so a following start edge is not missed.
                if (tick && smp_idx == IDX_S5) begin
                    next_state = ST_IDLE;
                    take_byte  = maj_now;
                    set_ferr   = !maj_now;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_idx   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            s3        <= 1'b1;
            s4        <= 1'b1;
            bit_val   <= 1'b1;
            armed     <= 1'b1;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= take_byte;
            frame_err <= set_ferr;
            if (take_byte) begin
                data <= shift;
            end

            if (set_ferr) begin
                armed <= 1'b0;
            end else if (state == ST_IDLE && rx_s) begin
                armed <= 1'b1;
            end

            if (state == ST_IDLE) begin
                smp_idx <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                smp_idx <= smp_idx + 1'b1;
                if (smp_idx == IDX_S3) s3 <= rx_s;
                if (smp_idx == IDX_S4) s4 <= rx_s;
                if (smp_idx == IDX_S5) bit_val <= maj_now;
                if (smp_idx == IDX_LAST && state == ST_DATA) begin
                    shift   <= {bit_val, shift[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample. Runs at a reduced clock so a
// sample tick is every 8 clks and a bit is 64 clks.
module tb_uart_rx_oversample;

    localparam int CLK_HZ = 614400;
    localparam int BAUD   = 9600;
    localparam int OVS    = 8;
    localparam int DIV    = 8;
    localparam int BIT    = 64;
    // sync (2) + divider counts up to the stop-bit sample 5 tick + 1 register
    localparam int LATENCY = DIV * (9 * OVS + 6) + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         overlap_cnt = 0;
    int         last_valid_cyc = 0;
    int         start_cyc = 0;
    logic       busy_mid = 1'b0;
    logic [7:0] got_q[$];

    uart_rx_oversample #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .OVS   (OVS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                got_q.push_back(data);
            end
            if (frame_err) ferr_cnt++;
            if (valid && frame_err) overlap_cnt++;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; optional 3-clk inverted glitch around sample 4 of a bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int stop_len, input int glitch_bit);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (BIT / 2) @(negedge clk);
        busy_mid = busy;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                repeat (38) @(negedge clk);
                rx = ~b[i];
                repeat (3) @(negedge clk);
                rx = b[i];
                repeat (23) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        rx = stop_val;
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_clean_5a();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, BIT, -1);
        idle(40);
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL clean_busy_mid got %b exp 1", busy_mid); end
        checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL clean_valid_cnt got %0d exp %0d", valid_cnt, v0 + 1); end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL clean_data got %h exp 5a", data); end
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL clean_ferr got %0d exp %0d", ferr_cnt, f0); end
        checks++; if (last_valid_cyc - start_cyc !== LATENCY) begin errors++; $display("FAIL clean_latency got %0d exp %0d", last_valid_cyc - start_cyc, LATENCY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_glitch_3c();
        int v0 = valid_cnt;
        send_frame(8'h3C, 1'b1, BIT, 2);
        idle(40);
        checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL glitch_valid_cnt got %0d exp %0d", valid_cnt, v0 + 1); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL glitch_data got %h exp 3c", data); end
    endtask

    task automatic test_start_glitch();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        rx = 1'b0;
        repeat (25) @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_glitch_busy got %b exp 1", busy); end
        repeat (60) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_glitch_idle got %b exp 0", busy); end
        idle(BIT * 10);
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL start_glitch_valid got %0d exp %0d", valid_cnt, v0); end
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL start_glitch_ferr got %0d exp %0d", ferr_cnt, f0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL start_glitch_data got %h exp 3c", data); end
    endtask

    task automatic test_frame_err();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'hFF, 1'b0, BIT * 3, -1);
        // Line still low: receiver must stay locked out.
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_lock_busy got %b exp 0", busy); end
        idle(100);
        checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_cnt got %0d exp %0d", ferr_cnt, f0 + 1); end
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL ferr_valid got %0d exp %0d", valid_cnt, v0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h exp 3c", data); end
        send_frame(8'h81, 1'b1, BIT, -1);
        idle(40);
        checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL after_ferr_valid got %0d exp %0d", valid_cnt, v0 + 1); end
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL after_ferr_data got %h exp 81", data); end
    endtask

    task automatic test_back_to_back();
        int f0 = ferr_cnt;
        got_q.delete();
        send_frame(8'h00, 1'b1, BIT, -1);
        send_frame(8'hFF, 1'b1, BIT, -1);
        idle(40);
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_q.size()); end
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h exp 00", got_q[0]); end
            checks++; if (got_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h exp ff", got_q[1]); end
        end
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL b2b_ferr got %0d exp %0d", ferr_cnt, f0); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] b = 8'hA5;
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = b[4];
        repeat (20) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL abort_data got %h exp 00", data); end
        idle(BIT * 10);
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL abort_valid got %0d exp %0d", valid_cnt, v0); end
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL abort_ferr got %0d exp %0d", ferr_cnt, f0); end
        send_frame(8'h11, 1'b1, BIT, -1);
        idle(40);
        checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL resume_valid got %0d exp %0d", valid_cnt, v0 + 1); end
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL resume_data got %h exp 11", data); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_5a();
        test_glitch_3c();
        test_start_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_abort();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", overlap_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
